word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-to-serial transmitter for the 16-bit bit-pattern path. It accepts a 16-bit word over a valid/ready handshake and emits it one bit per transfer, MSB (bit 15) first, with first/last framing flags. Its serial output is the stream form consumed by the pattern-detection side. It runs back-to-back without bubbles when the next word is offered during the last bit.

## Interface
- WIDTH, 16: word width in bits; must be ≥ 2.
- CNT_W, 4: bit-index counter width; must equal clog2(WIDTH).
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din_word  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din_word is valid.
- din_ready  output  1  block can accept a word this cycle (combinational).
- ser_bit  output  1  current serial bit (registered).
- ser_valid  output  1  ser_bit is valid (registered).
- ser_ready  input  1  downstream accepts ser_bit this cycle.
- ser_first  output  1  ser_bit is bit WIDTH-1 of a word.
- ser_last  output  1  ser_bit is bit 0 of a word.
- busy  output  1  a word is in flight (equals ser_valid).
- word_cnt  output  8  words fully transmitted; wraps 255→0.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-high.
- States:
  - IDLE: no word held.
  - SHIFT: a word is held, and ser_valid is 1.
- Registers: shreg[WIDTH-1:0], idx[CNT_W-1:0] (index of the bit on ser_bit), state, word_cnt.
- Bit transfer: a cycle with ser_valid=1 and ser_ready=1.
- Word accept: a cycle with din_valid=1 and din_ready=1.
- din_ready = (state==IDLE) OR (ser_valid AND ser_ready AND ser_last). It is forced to 0 while reset is high.
- ser_bit = shreg[WIDTH-1].
- ser_first = ser_valid AND (idx==WIDTH-1).
- ser_last = ser_valid AND (idx==0).
- Transitions:
  - IDLE + accept → SHIFT. Load shreg=din_word and idx=WIDTH-1.
  - SHIFT + transfer, idx≠0 → SHIFT. Shift shreg left by 1 (zero fill) and decrement idx.
  - SHIFT + transfer, idx==0, accept → SHIFT. Load the new word and set idx=WIDTH-1. word_cnt+1.
  - SHIFT + transfer, idx==0, no accept → IDLE. word_cnt+1. shreg is cleared to 0.
  - SHIFT, no transfer → hold all registers (stall). ser_bit, ser_first and ser_last stay stable.
- din_word is sampled only on accept. It may change freely at other times.
- word_cnt uses modulo-256 arithmetic and increments only on a last-bit transfer.

## Timing
- Reset values: state=IDLE, ser_valid=0, ser_bit=0, ser_first=0, ser_last=0, busy=0, word_cnt=0, idx=WIDTH-1.
- Reset asserted mid-word: the word is dropped immediately (asynchronous). No partial word_cnt increment.
- Load latency: accept at edge N → ser_valid=1 and the MSB on ser_bit after edge N.
- Full-throughput word (ser_ready held at 1): exactly WIDTH consecutive valid cycles.
- Back-to-back words: the next MSB appears on the cycle immediately after the previous LSB. There are no idle cycles.
- Accept from IDLE, or after a non-overlapped last bit: at least one cycle with ser_valid=0 lies between words.
- ser_ready=0 on the last bit: din_ready=0 (unless in IDLE), so no word is accepted.
- ser_ready may toggle on any cycle. Bit order and content are unaffected by stalls.

## Test plan
- Single word, ser_ready=1: din_word=16'h6C36 → ser_bit sequence 0,1,1,0,1,1,0,0,0,0,1,1,0,1,1,0 on 16 consecutive cycles. ser_first on cycle 1 only, ser_last on cycle 16 only. Then IDLE; word_cnt=1.
- Back-to-back: 16'hFFFF then 16'h0000, with din_valid held → 32 contiguous valid cycles (16 ones, then 16 zeros). din_ready high on cycle 16 only during SHIFT; word_cnt=2.
- Backpressure: 16'hA5A5 with ser_ready low every other cycle → the same 16-bit sequence 1010010110100101. Outputs held stable during stalls; 31 cycles total.
- Stall on last bit, with din_valid=1 and 16'h1234 pending → no accept while ser_ready=0. The accept happens on the cycle ser_ready rises, and 16'h1234 follows seamlessly.
- Reset mid-word: assert reset after 7 bits of 16'hF0F0 → outputs 0 immediately and word_cnt unchanged. After release, 16'h0001 transmits correctly.
- Counter wrap: 256 words → word_cnt returns to 0.

Source files
------------

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word on a valid/ready handshake
// and shifts it out MSB first, one bit per serial transfer, with first/last flags.
module word_serializer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_word,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic [7:0]       word_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] IDX_MSB = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_next;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] w_idx_next;
  logic [7:0]       r_word_cnt;
  logic [7:0]       w_word_cnt_next;

  logic w_transfer;
  logic w_idx_zero;
  logic w_accept;

  assign w_transfer = (r_state == S_SHIFT) && ser_ready;
  assign w_idx_zero = (r_idx == '0);
  // Accepting during the last-bit transfer is what makes back-to-back words bubble-free.
  assign din_ready  = !reset && ((r_state == S_IDLE) || (w_transfer && w_idx_zero));
  assign w_accept   = din_valid && din_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_idx      <= IDX_MSB;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_shreg    <= w_shreg_next;
      r_idx      <= w_idx_next;
      r_word_cnt <= w_word_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shreg_next    = r_shreg;
    w_idx_next      = r_idx;
    w_word_cnt_next = r_word_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_SHIFT;
          w_shreg_next = din_word;
          w_idx_next   = IDX_MSB;
        end
      end
      S_SHIFT: begin
        if (w_transfer) begin
          if (!w_idx_zero) begin
            w_shreg_next = {r_shreg[WIDTH-2:0], 1'b0};
            w_idx_next   = r_idx - 1'b1;
          end else begin
            w_word_cnt_next = r_word_cnt + 8'd1;
            w_idx_next      = IDX_MSB;
            if (w_accept) begin
              w_shreg_next = din_word;
            end else begin
              w_state_next = S_IDLE;
              w_shreg_next = '0;
            end
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign ser_valid = (r_state == S_SHIFT);
  assign busy      = ser_valid;
  assign ser_bit   = r_shreg[WIDTH-1];
  assign ser_first = ser_valid && (r_idx == IDX_MSB);
  assign ser_last  = ser_valid && w_idx_zero;
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: every accepted word becomes 16 expected serial entries in a
// queue; a negedge monitor pops one per serial transfer and checks flags, handshake and count.
module tb_word_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din_word;
  logic        din_valid;
  logic        din_ready;
  logic        ser_bit;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_first;
  logic        ser_last;
  logic        busy;
  logic [7:0]  word_cnt;

  word_serializer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .din_word  (din_word),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  exp_t       q[$];
  logic [7:0] model_cnt = 8'd0;
  int         vectors = 0;
  int         miscompares = 0;

  // ser_ready source: 0 always high, 1 alternating, 2 random, 3 manual
  int   ready_mode = 0;
  logic auto_ready = 1'b1;
  logic manual_ready = 1'b1;
  assign ser_ready = (ready_mode == 3) ? manual_ready : auto_ready;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: auto_ready = 1'b1;
      1: auto_ready = ~auto_ready;
      2: auto_ready = 1'($urandom_range(0, 1));
      default: auto_ready = auto_ready;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: expectations come purely from how many expected bits are still outstanding.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("ser_valid", 32'(ser_valid), 32'(q.size() != 0));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      chk("din_ready", 32'(din_ready), 32'((q.size() == 0) || (q.size() == 1 && ser_ready)));
      chk("word_cnt", 32'(word_cnt), 32'(model_cnt));
      if (q.size() == 0) begin
        chk("idle_bit", 32'({ser_bit, ser_first, ser_last}), 32'(0));
      end else begin
        e = q[0];
        chk("ser_bit", 32'(ser_bit), 32'(e.b));
        chk("ser_first", 32'(ser_first), 32'(e.f));
        chk("ser_last", 32'(ser_last), 32'(e.l));
        if (ser_ready) begin
          void'(q.pop_front());
          if (e.l) model_cnt = model_cnt + 8'd1;
        end
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    int   n;
    exp_t e;
    n = 0;
    din_word  = w;
    din_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!din_ready && n < 1000);
    if (!din_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got din_ready=0 expected 1 for word %0h", w);
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      #1;
      for (int i = 15; i >= 0; i--) begin
        e.b = w[i];
        e.f = (i == 15);
        e.l = (i == 0);
        q.push_back(e);
      end
    end
    din_valid = 1'b0;
    din_word  = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d bits pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    q.delete();
    model_cnt = 8'd0;
    #1;
    chk("rst_ser_valid", 32'(ser_valid), 32'(0));
    chk("rst_ser_bit", 32'(ser_bit), 32'(0));
    chk("rst_flags", 32'({ser_first, ser_last, busy}), 32'(0));
    chk("rst_word_cnt", 32'(word_cnt), 32'(0));
    chk("rst_din_ready", 32'(din_ready), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    din_valid = 1'b0;
    din_word  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_ser_valid", 32'(ser_valid), 32'(0));
    chk("init_outputs", 32'({ser_bit, ser_first, ser_last, busy}), 32'(0));
    chk("init_word_cnt", 32'(word_cnt), 32'(0));
    chk("init_din_ready", 32'(din_ready), 32'(0));
    reset = 1'b0;

    // single word at full throughput
    send_word(16'h6C36);
    drain();
    chk("single_cnt", 32'(word_cnt), 32'(1));

    // back-to-back words with din_valid held through the last bit
    send_word(16'hFFFF);
    send_word(16'h0000);
    drain();
    chk("b2b_cnt", 32'(word_cnt), 32'(3));

    // alternating backpressure
    ready_mode = 1;
    send_word(16'hA5A5);
    drain();
    ready_mode = 0;
    chk("bp_cnt", 32'(word_cnt), 32'(4));

    // stall on the last bit with the next word already offered
    manual_ready = 1'b1;
    ready_mode   = 3;
    send_word(16'hABCD);
    n = 0;
    while (q.size() != 1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_reach_last", 32'(q.size()), 32'(1));
    manual_ready = 1'b0;
    din_word     = 16'h1234;
    din_valid    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_no_ready", 32'(din_ready), 32'(0));
      chk("stall_last_held", 32'({ser_valid, ser_last}), 32'(2'b11));
    end
    @(posedge clk);
    #1;
    manual_ready = 1'b1;
    send_word(16'h1234);
    drain();
    ready_mode = 0;
    chk("stall_cnt", 32'(word_cnt), 32'(6));

    // reset in the middle of a word, then a clean word afterwards
    pulse_reset();
    send_word(16'hF0F0);
    repeat (7) @(posedge clk);
    chk("pre_reset_pending", 32'(q.size()), 32'(9));
    pulse_reset();
    send_word(16'h0001);
    drain();
    chk("post_reset_cnt", 32'(word_cnt), 32'(1));

    // random words, random backpressure, random gaps; 256 words wrap the counter
    pulse_reset();
    ready_mode = 2;
    for (int k = 0; k < 256; k++) begin
      send_word(16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    ready_mode = 0;
    @(posedge clk);
    #1;
    chk("wrap_cnt", 32'(word_cnt), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
